regfile_multiport: RTL and testbench
====================================

# regfile_multiport

Parametrised integer register file for the core: NREAD registered read ports and NWRITE write ports, with same-cycle write-to-read forwarding, fixed write-port priority and a hardwired zero register. It replaces the single-issue two-read/one-write register file and sits between decode (read) and writeback (write). An optional per-register scoreboard tracks pending writes for the issue stage.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREGS, 32, number of architectural registers (power of two, ≥2); AW = $clog2(NREGS)
- NREAD, 2, number of read ports (≥1)
- NWRITE, 1, number of write ports (≥1)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rstn  in  1  asynchronous active-low reset
- r_enable  in  1  capture read results this cycle
- rs_addr  in  NREAD*AW  read addresses, port i at [i*AW +: AW]
- rs_data  out  NREAD*XLEN  registered read data, port i at [i*XLEN +: XLEN]
- w_enable  in  NWRITE  per-port write enable
- w_addr  in  NWRITE*AW  write addresses, port j at [j*AW +: AW]
- w_data  in  NWRITE*XLEN  write data, port j at [j*XLEN +: XLEN]
- rsv_enable  in  1  reserve (mark busy) a destination register (scoreboard only)
- rsv_addr  in  AW  register to reserve (scoreboard only)
- rs_busy  out  NREAD  registered busy flag per read port (scoreboard only)

## Operation
- Reset (rstn low, asynchronous): all NREGS registers cleared to 0, rs_data = 0, rs_busy = 0, all busy bits = 0. Held while rstn low; first update on the first rising edge after release.
- Register 0 always reads 0; writes and reservations to address 0 are ignored.
- Write: for each j with w_enable[j]=1 and w_addr≠0, register w_addr takes w_data[j] at the edge.
- Write conflict: several enabled ports on the same address → highest-index port j wins; others dropped for that address.
- Read: when r_enable=1, rs_data[i] captures the value of register rs_addr[i]; when r_enable=0, rs_data holds its previous value (writes still proceed).
- Forwarding: if an enabled write this cycle targets rs_addr[i] (≠0), rs_data[i] captures the winning write's w_data, not the stale array value.
- Reads of the same address on multiple ports are independent and return identical data.
- Scoreboard busy bit per register: cleared by any enabled write to that address; set by rsv_enable to rsv_addr. Same-cycle set and clear on one address → set wins (new reservation supersedes retiring write).
- rs_busy[i], captured under r_enable with rs_data, equals the post-edge busy bit of rs_addr[i] (reflects same-cycle set/clear); always 0 for address 0.

## Timing
- Read latency: 1 cycle; addresses presented at edge N appear on rs_data/rs_busy after edge N.
- Write latency: written value visible via forwarding at the same edge; via array read from edge N+1.
- Reservation: rsv at edge N reflected in rs_busy captured at edge N.
- No handshake; all ports accepted every cycle.

## Configuration
- REGFILE_SCOREBOARD_EN defined: busy-bit array, rsv_enable/rsv_addr/rs_busy function as above.
- Undefined: no busy state; rsv_enable/rsv_addr ignored; rs_busy tied to 0. Register/forwarding behaviour identical.

## Test plan
- Reset: write 0xDEADBEEF to x5, assert rstn low mid-cycle → rs_data=0 immediately; after release read x5 → 0.
- Forwarding: w_enable=1, w_addr=7, w_data=0x12345678, rs_addr[0]=7, r_enable=1 → rs_data[0]=0x12345678 next cycle; x7 read later → same.
- Zero register: write 0xFFFFFFFF to x0, read x0 same and next cycle → 0; rsv to x0 → rs_busy=0.
- Write conflict (NWRITE=2): both ports write x3, port0=0x1, port1=0x2 → x3=0x2, forwarded read=0x2.
- Read hold: r_enable=0 while x4 written 0xAA → rs_data unchanged; r_enable=1 → 0xAA.
- Scoreboard (REGFILE_SCOREBOARD_EN): rsv x9 → rs_busy=1; write x9 → 0; write x9 plus rsv x9 same cycle → busy stays 1.

Source files
------------

// File: rtl/regfile_multiport_if.sv
// +------------------------------------------------------------------+
// | Module  : regfile_multiport_if                                   |
// | Brief   : Read/write/reservation bundle for regfile_multiport.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

interface regfile_multiport_if #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
);
   localparam int AW = $clog2(NREGS);

   logic                   r_enable;
   logic [NREAD*AW-1:0]    rs_addr;
   logic [NREAD*XLEN-1:0]  rs_data;
   logic [NWRITE-1:0]      w_enable;
   logic [NWRITE*AW-1:0]   w_addr;
   logic [NWRITE*XLEN-1:0] w_data;
   logic                   rsv_enable;
   logic [AW-1:0]          rsv_addr;
   logic [NREAD-1:0]       rs_busy;

   modport master (
      output r_enable, rs_addr, w_enable, w_addr, w_data, rsv_enable, rsv_addr,
      input  rs_data, rs_busy
   );

   modport slave (
      input  r_enable, rs_addr, w_enable, w_addr, w_data, rsv_enable, rsv_addr,
      output rs_data, rs_busy
   );
endinterface

`default_nettype wire

// File: rtl/regfile_multiport.sv
// +------------------------------------------------------------------+
// | Module  : regfile_multiport                                      |
// | Brief   : Multi-port register file, registered reads, write      |
// |           forwarding, x0 hardwired; optional busy scoreboard     |
// |           enabled by defining REGFILE_SCOREBOARD_EN.             |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module regfile_multiport #(
   parameter int XLEN   = 32,
   parameter int NREGS  = 32,
   parameter int NREAD  = 2,
   parameter int NWRITE = 1
) (
   input  wire logic          clk,
   input  wire logic          rstn,
   regfile_multiport_if.slave bus
);
   localparam int AW = $clog2(NREGS);

   logic [XLEN-1:0]       regs_q [NREGS];
   logic [XLEN-1:0]       regs_d [NREGS];
   logic [NREAD*XLEN-1:0] rs_data_q, rs_data_d;
   logic [NREAD-1:0]      rs_busy_q, rs_busy_d;
   logic [NREGS-1:0]      busy_d;

   // Later ports overwrite earlier ones, so the highest-index port wins a conflict.
   always_comb begin
      regs_d = regs_q;
      for (int j = 0; j < NWRITE; j++) begin
         if (bus.w_enable[j] && (bus.w_addr[j*AW +: AW] != '0)) begin
            regs_d[bus.w_addr[j*AW +: AW]] = bus.w_data[j*XLEN +: XLEN];
         end
      end
   end

`ifdef REGFILE_SCOREBOARD_EN
   logic [NREGS-1:0] busy_q;

   // Reservation is applied after retirement so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      for (int j = 0; j < NWRITE; j++) begin
         if (bus.w_enable[j] && (bus.w_addr[j*AW +: AW] != '0)) begin
            busy_d[bus.w_addr[j*AW +: AW]] = 1'b0;
         end
      end
      if (bus.rsv_enable && (bus.rsv_addr != '0)) begin
         busy_d[bus.rsv_addr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end
`else
   logic unused_rsv;

   assign busy_d     = '0;
   assign unused_rsv = ^{bus.rsv_enable, bus.rsv_addr};
`endif

   // Reading the post-write image gives forwarding of the winning write for free.
   always_comb begin
      rs_data_d = rs_data_q;
      rs_busy_d = rs_busy_q;
      if (bus.r_enable) begin
         for (int i = 0; i < NREAD; i++) begin
            if (bus.rs_addr[i*AW +: AW] == '0) begin
               rs_data_d[i*XLEN +: XLEN] = '0;
               rs_busy_d[i]              = 1'b0;
            end else begin
               rs_data_d[i*XLEN +: XLEN] = regs_d[bus.rs_addr[i*AW +: AW]];
               rs_busy_d[i]              = busy_d[bus.rs_addr[i*AW +: AW]];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int k = 0; k < NREGS; k++) begin
            regs_q[k] <= '0;
         end
         rs_data_q <= '0;
         rs_busy_q <= '0;
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            regs_q[k] <= regs_d[k];
         end
         rs_data_q <= rs_data_d;
         rs_busy_q <= rs_busy_d;
      end
   end

   assign bus.rs_data = rs_data_q;
   assign bus.rs_busy = rs_busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regfile_multiport.sv
// +------------------------------------------------------------------+
// | Module  : tb_regfile_multiport                                   |
// | Brief   : Directed self-checking bench for regfile_multiport.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_regfile_multiport;
   localparam int XLEN   = 32;
   localparam int NREGS  = 32;
   localparam int NREAD  = 2;
   localparam int NWRITE = 2;

`ifdef REGFILE_SCOREBOARD_EN
   localparam logic SB = 1'b1;
`else
   localparam logic SB = 1'b0;
`endif

   logic clk;
   logic rstn;
   int   errors;
   int   checks;

   regfile_multiport_if #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) bus_if ();

   regfile_multiport #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(NREAD), .NWRITE(NWRITE)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic re, input logic [4:0] ra0, input logic [4:0] ra1,
                        input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                        input logic [4:0] wa1, input logic [31:0] wd1,
                        input logic rsve, input logic [4:0] rsva);
      bus_if.r_enable   = re;
      bus_if.rs_addr    = {ra1, ra0};
      bus_if.w_enable   = we;
      bus_if.w_addr     = {wa1, wa0};
      bus_if.w_data     = {wd1, wd0};
      bus_if.rsv_enable = rsve;
      bus_if.rsv_addr   = rsva;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] rd(input int p);
      return bus_if.rs_data[p*XLEN +: XLEN];
   endfunction

   initial begin
      errors = 0;
      checks = 0;
      rstn   = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      tick();
      check("reset_rs_data0", rd(0), 32'h0);
      check("reset_rs_data1", rd(1), 32'h0);
      check("reset_rs_busy", {30'b0, bus_if.rs_busy}, 32'h0);
      rstn = 1'b1;

      // Write x5 with a forwarded read, then reset asynchronously mid-cycle.
      drive(1'b1, 5'd5, 5'd0, 2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("x5_forward", rd(0), 32'hDEADBEEF);
      drive(1'b0, 5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      #3;
      rstn = 1'b0;
      #1;
      check("async_reset_data", rd(0), 32'h0);
      tick();
      rstn = 1'b1;
      drive(1'b1, 5'd5, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("x5_after_reset", rd(0), 32'h0);

      // Forwarding to both read ports from the same address.
      drive(1'b1, 5'd7, 5'd7, 2'b01, 5'd7, 32'h12345678, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("x7_fwd_p0", rd(0), 32'h12345678);
      check("x7_fwd_p1", rd(1), 32'h12345678);
      drive(1'b1, 5'd0, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("x7_array_p1", rd(1), 32'h12345678);
      check("x0_read_p0", rd(0), 32'h0);

      // Zero register ignores writes and reservations.
      drive(1'b1, 5'd0, 5'd0, 2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0);
      tick();
      check("x0_same_cycle", rd(0), 32'h0);
      check("x0_busy", {31'b0, bus_if.rs_busy[0]}, 32'h0);
      drive(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("x0_next_cycle", rd(1), 32'h0);

      // Write conflict: port 1 wins.
      drive(1'b1, 5'd3, 5'd0, 2'b11, 5'd3, 32'h1, 5'd3, 32'h2, 1'b0, 5'd0);
      tick();
      check("conflict_fwd", rd(0), 32'h2);
      drive(1'b1, 5'd0, 5'd3, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("conflict_array", rd(1), 32'h2);

      // Two independent writes in one cycle.
      drive(1'b1, 5'd10, 5'd11, 2'b11, 5'd10, 32'h11, 5'd11, 32'h22, 1'b0, 5'd0);
      tick();
      check("dual_write_p0", rd(0), 32'h11);
      check("dual_write_p1", rd(1), 32'h22);

      // Read hold while a write proceeds.
      drive(1'b0, 5'd4, 5'd4, 2'b01, 5'd4, 32'hAA, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("hold_p0", rd(0), 32'h11);
      check("hold_p1", rd(1), 32'h22);
      drive(1'b1, 5'd4, 5'd10, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("x4_after_hold", rd(0), 32'hAA);
      check("x10_array", rd(1), 32'h11);

      // Scoreboard: reserve, retire, then reserve+retire in one cycle.
      drive(1'b1, 5'd9, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9);
      tick();
      check("sb_rsv", {31'b0, bus_if.rs_busy[0]}, {31'b0, SB});
      drive(1'b1, 5'd9, 5'd9, 2'b10, 5'd0, 32'h0, 5'd9, 32'h99, 1'b0, 5'd0);
      tick();
      check("sb_retire_busy", {31'b0, bus_if.rs_busy[1]}, 32'h0);
      check("sb_retire_data", rd(1), 32'h99);
      drive(1'b1, 5'd9, 5'd0, 2'b01, 5'd9, 32'h55, 5'd0, 32'h0, 1'b1, 5'd9);
      tick();
      check("sb_set_wins", {31'b0, bus_if.rs_busy[0]}, {31'b0, SB});
      check("sb_set_data", rd(0), 32'h55);
      drive(1'b1, 5'd0, 5'd9, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0);
      tick();
      check("sb_busy_persist", {31'b0, bus_if.rs_busy[1]}, {31'b0, SB});
      check("sb_x0_port", {31'b0, bus_if.rs_busy[0]}, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
